// File: rtl/flash_rdseq_if.sv
// rtl/flash_rdseq_if.sv - host and flash-side signal bundle for the fast-read sequencer
interface flash_rdseq_if;
  logic        req;
  logic        stat_req;
  logic [23:0] addr;
  logic [15:0] len;
  logic        abort;
  logic        busy;
  logic [7:0]  rdata;
  logic        rvalid;
  logic        done;
  logic        f_ready;
  logic        f_wr;
  logic [7:0]  f_dout;
  logic [2:0]  f_format;
  logic [3:0]  f_prescale;
  logic [7:0]  f_din;

  // Environment side: issues requests and plays the flash byte engine
  modport master (
    output req, stat_req, addr, len, abort, f_ready, f_din,
    input  busy, rdata, rvalid, done, f_wr, f_dout, f_format, f_prescale
  );

  // Sequencer side
  modport slave (
    input  req, stat_req, addr, len, abort, f_ready, f_din,
    output busy, rdata, rvalid, done, f_wr, f_dout, f_format, f_prescale
  );
endinterface

// File: rtl/flash_rdseq.sv
// rtl/flash_rdseq.sv - SPI flash fast-read / status-read byte sequencer
module flash_rdseq #(
  parameter logic [2:0] FMT      = 3'b001,
  parameter logic [3:0] PRESCALE = 4'd3
) (
  input logic          clk,
  input logic          arstn,
  flash_rdseq_if.slave bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_A2, S_A1, S_A0, S_DUMMY, S_DATA, S_CAPT, S_END, S_FIN
  } state_t;

  // Each byte step walks SEND -> PULSE -> SKIP -> WAIT; SKIP ignores the
  // cycle right after the pulse where f_ready may not have dropped yet.
  typedef enum logic [1:0] {P_SEND, P_PULSE, P_SKIP, P_WAIT} phase_t;

  state_t      r_state, w_state_n;
  phase_t      r_phase, w_phase_n;
  logic        r_busy, w_busy_n;
  logic        r_rvalid, w_rvalid_n;
  logic        r_done, w_done_n;
  logic        r_f_wr, w_f_wr_n;
  logic [2:0]  r_f_format, w_f_format_n;
  logic [7:0]  r_f_dout, w_f_dout_n;
  logic [7:0]  r_rdata, w_rdata_n;
  logic [15:0] r_cnt, w_cnt_n;
  logic [23:0] r_addr, w_addr_n;
  logic        r_stat, w_stat_n;
  logic        r_abort, w_abort_n;

  logic        w_in_txn;
  logic        w_abt;
  logic        w_step_state;
  logic        w_step_done;
  logic [7:0]  w_byte;

  assign w_in_txn     = r_state inside {S_CMD, S_A2, S_A1, S_A0, S_DUMMY, S_DATA, S_CAPT};
  assign w_abt        = w_in_txn && (r_abort || bus.abort);
  assign w_step_state = r_state inside {S_CMD, S_A2, S_A1, S_A0, S_DUMMY, S_DATA, S_END};

  // Byte to transmit for the step owned by the current state
  always_comb begin
    w_byte = 8'hFF;
    case (r_state)
      S_CMD:   w_byte = r_stat ? 8'h05 : 8'h0B;
      S_A2:    w_byte = r_addr[23:16];
      S_A1:    w_byte = r_addr[15:8];
      S_A0:    w_byte = r_addr[7:0];
      default: w_byte = 8'hFF;
    endcase
  end

  // Next-state and next-output decode for the sequencer
  always_comb begin
    w_state_n   = r_state;
    w_phase_n   = r_phase;
    w_busy_n    = r_busy;
    w_rvalid_n  = 1'b0;
    w_done_n    = 1'b0;
    w_f_wr_n    = 1'b0;
    w_f_dout_n  = r_f_dout;
    w_rdata_n   = r_rdata;
    w_cnt_n     = r_cnt;
    w_addr_n    = r_addr;
    w_stat_n    = r_stat;
    w_abort_n   = w_abt;
    w_step_done = 1'b0;

    if (w_step_state) begin
      case (r_phase)
        P_SEND: begin
          if (bus.f_ready && !r_f_wr) begin
            w_f_wr_n   = 1'b1;
            w_f_dout_n = w_byte;
            w_phase_n  = P_PULSE;
          end
        end
        P_PULSE: w_phase_n = P_SKIP;
        P_SKIP:  w_phase_n = P_WAIT;
        default: begin
          if (bus.f_ready) begin
            w_step_done = 1'b1;
            w_phase_n   = P_SEND;
          end
        end
      endcase
    end

    case (r_state)
      S_IDLE: begin
        w_phase_n = P_SEND;
        if (bus.stat_req) begin
          w_stat_n  = 1'b1;
          w_cnt_n   = 16'd1;
          w_busy_n  = 1'b1;
          w_state_n = S_CMD;
        end else if (bus.req) begin
          w_stat_n  = 1'b0;
          w_cnt_n   = bus.len;
          w_addr_n  = bus.addr;
          w_busy_n  = 1'b1;
          w_state_n = S_CMD;
        end
      end
      S_CMD:   if (w_step_done) w_state_n = w_abt ? S_END : (r_stat ? S_DATA : S_A2);
      S_A2:    if (w_step_done) w_state_n = w_abt ? S_END : S_A1;
      S_A1:    if (w_step_done) w_state_n = w_abt ? S_END : S_A0;
      S_A0:    if (w_step_done) w_state_n = w_abt ? S_END : S_DUMMY;
      S_DUMMY: if (w_step_done) w_state_n = (w_abt || r_cnt == 16'd0) ? S_END : S_DATA;
      S_DATA:  if (w_step_done) w_state_n = w_abt ? S_END : S_CAPT;
      S_CAPT: begin
        if (w_abt) begin
          w_state_n = S_END;
        end else if (bus.f_ready) begin
          w_rdata_n  = bus.f_din;
          w_rvalid_n = 1'b1;
          w_cnt_n    = r_cnt - 16'd1;
          w_state_n  = (r_cnt == 16'd1) ? S_END : S_DATA;
        end
      end
      S_END: begin
        if (w_step_done) begin
          w_state_n = S_FIN;
          w_done_n  = 1'b1;
          w_busy_n  = 1'b0;
        end
      end
      S_FIN:   w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase

    w_f_format_n = (w_state_n inside {S_CMD, S_A2, S_A1, S_A0, S_DUMMY, S_DATA, S_CAPT}) ? FMT : 3'b000;
  end

  // State and registered outputs, cleared asynchronously
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_state    <= S_IDLE;
      r_phase    <= P_SEND;
      r_busy     <= 1'b0;
      r_rvalid   <= 1'b0;
      r_done     <= 1'b0;
      r_f_wr     <= 1'b0;
      r_f_format <= 3'b000;
      r_f_dout   <= 8'h00;
      r_rdata    <= 8'h00;
      r_cnt      <= 16'd0;
      r_addr     <= 24'd0;
      r_stat     <= 1'b0;
      r_abort    <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_phase    <= w_phase_n;
      r_busy     <= w_busy_n;
      r_rvalid   <= w_rvalid_n;
      r_done     <= w_done_n;
      r_f_wr     <= w_f_wr_n;
      r_f_format <= w_f_format_n;
      r_f_dout   <= w_f_dout_n;
      r_rdata    <= w_rdata_n;
      r_cnt      <= w_cnt_n;
      r_addr     <= w_addr_n;
      r_stat     <= w_stat_n;
      r_abort    <= w_abort_n;
    end
  end

  assign bus.busy       = r_busy;
  assign bus.rvalid     = r_rvalid;
  assign bus.done       = r_done;
  assign bus.rdata      = r_rdata;
  assign bus.f_wr       = r_f_wr;
  assign bus.f_dout     = r_f_dout;
  assign bus.f_format   = r_f_format;
  assign bus.f_prescale = PRESCALE;

endmodule

// File: tb/tb_flash_rdseq.sv
// tb/tb_flash_rdseq.sv - directed self-checking bench for flash_rdseq
module tb_flash_rdseq;
  logic clk = 1'b0;
  logic arstn = 1'b0;
  always #5 clk = ~clk;

  flash_rdseq_if bus ();

  flash_rdseq #(.FMT(3'b001), .PRESCALE(4'd3)) dut (
    .clk   (clk),
    .arstn (arstn),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Flash byte engine model
  logic [7:0]  mem [256];
  logic [7:0]  stat_byte;
  logic [7:0]  pend;
  logic [7:0]  cmd;
  logic [23:0] maddr;
  logic [7:0]  ma;
  int          dly;
  int          idx;

  always @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      bus.f_ready <= 1'b1;
      bus.f_din   <= 8'h00;
      dly <= 0; idx <= 0; cmd <= 8'h00; maddr <= 24'd0; pend <= 8'h00;
    end else if (bus.f_wr) begin
      bus.f_ready <= 1'b0;
      dly <= 3;
      if (bus.f_format == 3'b000) begin
        idx  <= 0;
        pend <= 8'hFF;
      end else begin
        idx <= idx + 1;
        if (idx == 0) cmd <= bus.f_dout;
        if (idx == 1) maddr[23:16] <= bus.f_dout;
        if (idx == 2) maddr[15:8]  <= bus.f_dout;
        if (idx == 3) maddr[7:0]   <= bus.f_dout;
        ma = maddr[7:0] + 8'(idx - 5);
        if (idx >= 1 && cmd == 8'h05)      pend <= stat_byte;
        else if (idx >= 5 && cmd == 8'h0B) pend <= mem[ma];
        else                               pend <= 8'h00;
      end
    end else if (dly != 0) begin
      dly <= dly - 1;
      if (dly == 1) begin
        bus.f_ready <= 1'b1;
        bus.f_din   <= pend;
      end
    end
  end

  // Monitor: logs bytes sent, bytes received and done pulses
  logic [7:0] log_dout [128];
  logic [2:0] log_fmt  [128];
  logic [7:0] rv_data  [128];
  int wr_cnt = 0, rv_cnt = 0, done_cnt = 0;
  logic prev_wr = 1'b0;

  always @(negedge clk) begin
    if (arstn) begin
      if (bus.f_wr) begin
        check("wr_while_ready", bus.f_ready, 1);
        check("wr_single_pulse", prev_wr, 0);
        if (wr_cnt < 128) begin
          log_dout[wr_cnt] = bus.f_dout;
          log_fmt[wr_cnt]  = bus.f_format;
        end
        wr_cnt++;
      end
      if (bus.rvalid) begin
        if (rv_cnt < 128) rv_data[rv_cnt] = bus.rdata;
        rv_cnt++;
      end
      if (bus.done) done_cnt++;
    end
    prev_wr = bus.f_wr;
  end

  task automatic clear_logs();
    wr_cnt = 0; rv_cnt = 0; done_cnt = 0;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic start(input logic r, input logic s, input logic [23:0] a, input logic [15:0] l);
    @(negedge clk);
    bus.req = r; bus.stat_req = s; bus.addr = a; bus.len = l;
    @(negedge clk);
    bus.req = 1'b0; bus.stat_req = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max);
    for (int i = 0; i < max; i++) begin
      if (done_cnt > 0) break;
      @(negedge clk);
    end
    check(tag, done_cnt > 0, 1);
    cycles(5);
  endtask

  logic [7:0] exp_rd  [10];
  logic [7:0] exp_z   [6];

  initial begin
    bus.req = 1'b0; bus.stat_req = 1'b0; bus.abort = 1'b0;
    bus.addr = 24'd0; bus.len = 16'd0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i ^ 8'h5A);
    mem[8'h10] = 8'h11; mem[8'h11] = 8'h22; mem[8'h12] = 8'h33; mem[8'h13] = 8'h44;
    stat_byte = 8'h00;

    // Reset values
    #12;
    check("rst_busy", bus.busy, 0);
    check("rst_rvalid", bus.rvalid, 0);
    check("rst_done", bus.done, 0);
    check("rst_f_wr", bus.f_wr, 0);
    check("rst_fmt", bus.f_format, 0);
    check("rst_dout", bus.f_dout, 0);
    check("rst_rdata", bus.rdata, 0);
    check("prescale", bus.f_prescale, 3);
    @(negedge clk); arstn = 1'b1;
    cycles(2);

    // Fast read of 4 bytes at 0x10
    clear_logs();
    start(1'b1, 1'b0, 24'h000010, 16'd4);
    check("rd_busy", bus.busy, 1);
    wait_done("rd_timeout", 400);
    exp_rd = '{8'h0B, 8'h00, 8'h00, 8'h10, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    check("rd_wr_cnt", wr_cnt, 10);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("rd_dout%0d", i), log_dout[i], exp_rd[i]);
      check($sformatf("rd_fmt%0d", i), log_fmt[i], (i == 9) ? 3'b000 : 3'b001);
    end
    check("rd_rv_cnt", rv_cnt, 4);
    check("rd_data0", rv_data[0], 8'h11);
    check("rd_data1", rv_data[1], 8'h22);
    check("rd_data2", rv_data[2], 8'h33);
    check("rd_data3", rv_data[3], 8'h44);
    check("rd_done_cnt", done_cnt, 1);
    check("rd_busy_end", bus.busy, 0);
    check("rd_fmt_idle", bus.f_format, 0);

    // Status reads: 0x00 and 0xA5
    for (int k = 0; k < 2; k++) begin
      stat_byte = (k == 0) ? 8'h00 : 8'hA5;
      clear_logs();
      start(1'b0, 1'b1, 24'h0, 16'd0);
      wait_done("st_timeout", 200);
      check("st_wr_cnt", wr_cnt, 3);
      check("st_dout0", log_dout[0], 8'h05);
      check("st_dout1", log_dout[1], 8'hFF);
      check("st_dout2", log_dout[2], 8'hFF);
      check("st_fmt1", log_fmt[1], 3'b001);
      check("st_fmt2", log_fmt[2], 3'b000);
      check("st_rv_cnt", rv_cnt, 1);
      check("st_data", rv_data[0], (k == 0) ? 8'h00 : 8'hA5);
      check("st_done_cnt", done_cnt, 1);
    end

    // len = 0: command, address, dummy, then chip-select release
    clear_logs();
    start(1'b1, 1'b0, 24'hABCDEF, 16'd0);
    wait_done("z_timeout", 200);
    exp_z = '{8'h0B, 8'hAB, 8'hCD, 8'hEF, 8'hFF, 8'hFF};
    check("z_wr_cnt", wr_cnt, 6);
    for (int i = 0; i < 6; i++) check($sformatf("z_dout%0d", i), log_dout[i], exp_z[i]);
    check("z_fmt4", log_fmt[4], 3'b001);
    check("z_fmt5", log_fmt[5], 3'b000);
    check("z_rv_cnt", rv_cnt, 0);
    check("z_done_cnt", done_cnt, 1);

    // Simultaneous req and stat_req: status wins, req dropped
    clear_logs();
    stat_byte = 8'h3C;
    start(1'b1, 1'b1, 24'h000010, 16'd4);
    wait_done("both_timeout", 200);
    cycles(60);
    check("both_dout0", log_dout[0], 8'h05);
    check("both_wr_cnt", wr_cnt, 3);
    check("both_rv_cnt", rv_cnt, 1);
    check("both_data", rv_data[0], 8'h3C);
    check("both_busy", bus.busy, 0);

    // Abort after the third received byte of a 100-byte read
    clear_logs();
    start(1'b1, 1'b0, 24'h000020, 16'd100);
    for (int i = 0; i < 400; i++) begin
      if (rv_cnt >= 3) break;
      @(negedge clk);
    end
    check("ab_reach3", rv_cnt >= 3, 1);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    wait_done("ab_timeout", 200);
    check("ab_rv_cnt", rv_cnt, 3);
    check("ab_data2", rv_data[2], mem[8'h22]);
    check("ab_wr_max", wr_cnt <= 10, 1);
    check("ab_last_fmt", log_fmt[wr_cnt-1], 3'b000);
    check("ab_done_cnt", done_cnt, 1);
    check("ab_busy", bus.busy, 0);

    // Asynchronous reset during the data phase
    clear_logs();
    start(1'b1, 1'b0, 24'h000010, 16'd4);
    for (int i = 0; i < 400; i++) begin
      if (rv_cnt >= 1) break;
      @(negedge clk);
    end
    check("ar_reach", rv_cnt >= 1, 1);
    @(posedge clk);
    #2 arstn = 1'b0;
    #1;
    check("ar_busy", bus.busy, 0);
    check("ar_rvalid", bus.rvalid, 0);
    check("ar_done", bus.done, 0);
    check("ar_f_wr", bus.f_wr, 0);
    check("ar_fmt", bus.f_format, 0);
    check("ar_dout", bus.f_dout, 0);
    check("ar_rdata", bus.rdata, 0);
    cycles(2);
    arstn = 1'b1;
    cycles(2);
    clear_logs();
    start(1'b1, 1'b0, 24'h000010, 16'd1);
    wait_done("ar2_timeout", 200);
    check("ar2_dout0", log_dout[0], 8'h0B);
    check("ar2_wr_cnt", wr_cnt, 7);
    check("ar2_rv_cnt", rv_cnt, 1);
    check("ar2_data", rv_data[0], 8'h11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/flash_rdseq.md
FLASH_RDSEQ -- requirements
Module: flash_rdseq

Interface
REQ-001 Parameter FMT, default 3'b001, SPI bus format driven while chip select is active (must be non-zero).
REQ-002 Parameter PRESCALE, default 4'd3, flash configuration value driven on f_prescale at all times.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 arstn  input  1  reset, asynchronous, active-low.
REQ-005 req  input  1  start fast-read of len bytes at addr; sampled only in IDLE.
REQ-006 stat_req  input  1  start status read (one byte); sampled only in IDLE.
REQ-007 addr  input  24  flash byte address, latched on accepted req.
REQ-008 len  input  16  byte count, latched on accepted req; 0 means no data bytes.
REQ-009 abort  input  1  terminate current transaction early.
REQ-010 busy  output  1  high from acceptance until return to IDLE.
REQ-011 rdata  output  8  received byte, valid while rvalid high.
REQ-012 rvalid  output  1  one-cycle strobe per received byte.
REQ-013 done  output  1  one-cycle strobe at transaction end.
REQ-014 f_ready  input  1  flash interface ready for next byte.
REQ-015 f_wr  output  1  flash byte transmit strobe.
REQ-016 f_dout  output  8  byte sent to flash.
REQ-017 f_format  output  3  bus format; 000 = chip select inactive.
REQ-018 f_prescale  output  4  flash configuration, equals PRESCALE.
REQ-019 f_din  input  8  byte received from flash.

Function
REQ-020 All outputs are registered.
REQ-021 f_wr is asserted only in a cycle where f_ready=1 and f_wr was 0 in the previous cycle; f_wr is always a single-cycle pulse.
REQ-022 Each byte transaction is a "step": f_wr pulse with f_dout/f_format, then wait until f_ready=1 is sampled in a cycle other than the one immediately after the pulse.
REQ-023 States: IDLE, CMD, A2, A1, A0, DUMMY, DATA, CAPT, END, FIN.
REQ-024 IDLE: stat_req has priority over req; simultaneous assertion accepts stat_req, and req is ignored (not queued).
REQ-025 req/stat_req/abort asserted while busy=1 and not in IDLE are ignored, except as REQ-032.
REQ-026 Read sequence: CMD step f_dout=0x0B; A2/A1/A0 steps send addr[23:16], addr[15:8], addr[7:0]; DUMMY step sends 0xFF; all with f_format=FMT.
REQ-027 Status sequence: CMD step f_dout=0x05, then one DATA step; the DUMMY step is skipped.
REQ-028 DATA step sends 0xFF with f_format=FMT; CAPT waits for f_ready, then latches rdata<=f_din with rvalid=1 for exactly that one following cycle.
REQ-029 A 16-bit remaining counter is loaded with len (status: 1) and decremented per captured byte; when it reaches 0, go to END.
REQ-030 len=0: DUMMY goes directly to END; no rvalid is issued.
REQ-031 END: one step with f_format=000, f_dout=0xFF (chip-select release); then FIN pulses done=1 for one cycle and returns to IDLE with busy=0 in the same cycle.
REQ-032 abort in any state CMD..CAPT: the pending step completes, no further rvalid is issued, then go to END. abort in END/FIN has no effect.
REQ-033 f_format=FMT from CMD through CAPT, and 000 in IDLE, END, FIN.
REQ-034 Latency from accepted req to first rvalid: ≥ 6 steps. Status: ≥ 2 steps.

Reset
REQ-035 arstn=0 immediately forces state=IDLE, busy=0, rvalid=0, done=0, f_wr=0, f_format=000, f_dout=0x00, rdata=0x00, counter=0.
REQ-036 Reset mid-transaction discards the transaction without an END step; the first transaction after reset begins with CMD.

Verification
REQ-037 req, addr=0x000010, len=4, flash holding 11 22 33 44 at 0x10 -> f_dout sequence 0B 00 00 10 FF FF FF FF FF FF(fmt 000); rvalid x4 with rdata 11,22,33,44; one done pulse.
REQ-038 stat_req with status byte 0x00 -> f_dout 05 FF FF(fmt 000); one rvalid with rdata=0x00; done; total of 3 f_wr pulses.
REQ-039 req with len=0 -> 5 steps at fmt FMT plus END step; no rvalid; done pulse.
REQ-040 req and stat_req asserted in the same cycle -> first f_dout is 0x05; req is not serviced afterwards.
REQ-041 len=100 with abort pulsed after the 3rd rvalid -> at most 1 further step before END; exactly 3 rvalid; done pulse; busy falls.
REQ-042 arstn pulsed low during DATA -> all outputs at reset values asynchronously; subsequent req starts with 0x0B; no f_wr while f_ready=0, checked for the whole run.
